sopc_run_monitor: RTL

- Synthesizable run controller and trace monitor for the min SOPC. Replaces hard-coded reset delays and fixed-length runs.
- Holds the core in reset for a programmable number of cycles, then releases it.
- Records every register-file write-back into a trace FIFO, stamped with the cycle number. A valid/ready port drains the FIFO.
- Ends the run on halt detection (PC stable for a set number of cycles, e.g. a "b ." loop) or on cycle timeout.

---
 rtl/sopc_run_monitor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sopc_run_monitor.sv
// Run controller and write-back trace monitor for the min SOPC: holds the core
// in reset, runs it, records register writes into a FWFT FIFO, ends on halt/timeout.
module sopc_run_monitor #(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 32,
  parameter int CYC_W        = 24,
  parameter int DEPTH        = 16,
  parameter int RESET_CYCLES = 4,
  parameter int HALT_STABLE  = 8,
  parameter int MAX_CYCLES   = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      core_rst_o,
  input  logic [PC_W-1:0]           pc_i,
  input  logic                      wb_we_i,
  input  logic [4:0]                wb_addr_i,
  input  logic [DATA_W-1:0]         wb_data_i,
  output logic                      trace_valid_o,
  input  logic                      trace_ready_i,
  output logic [CYC_W+5+DATA_W-1:0] trace_data_o,
  output logic                      trace_overflow_o,
  output logic [7:0]                drop_cnt_o,
  output logic [CYC_W-1:0]          cycle_cnt_o,
  output logic                      halted_o,
  output logic                      timeout_o,
  output logic                      done_o,
  output logic [1:0]                state_o
);

  localparam int TW = CYC_W + 5 + DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(HALT_STABLE);

  localparam logic [HW-1:0]    HOLD_LAST   = HW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0]    STABLE_LAST = SW'(HALT_STABLE - 2);
  localparam logic [CYC_W-1:0] CYC_LAST    = CYC_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [HW-1:0]    hold_cnt;
  logic [SW-1:0]    stable_cnt;
  logic [PC_W-1:0]  prev_pc;
  logic [CYC_W-1:0] cycle_cnt;
  logic             pc_same;
  logic             hold_done;
  logic             halt_hit;
  logic             timeout_hit;

  assign pc_same     = (pc_i == prev_pc);
  assign hold_done   = (state == ST_HOLD) && (hold_cnt == HOLD_LAST);
  // Stable counter reaches HALT_STABLE-1 on this edge.
  assign halt_hit    = (state == ST_RUN) && pc_same && (stable_cnt == STABLE_LAST);
  assign timeout_hit = (state == ST_RUN) && (cycle_cnt == CYC_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_HOLD;
    else      state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD: if (hold_done) state_nxt = ST_RUN;
      ST_RUN: begin
        if (halt_hit)         state_nxt = ST_HALT;
        else if (timeout_hit) state_nxt = ST_TIMEOUT;
      end
      default: state_nxt = state;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    core_rst_o = (state == ST_HOLD);
    halted_o   = (state == ST_HALT);
    timeout_o  = (state == ST_TIMEOUT);
    done_o     = (state == ST_HALT) || (state == ST_TIMEOUT);
    state_o    = state;
  end

  // ---------------- run counters ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt   <= '0;
      stable_cnt <= '0;
      prev_pc    <= '0;
      cycle_cnt  <= '0;
    end else begin
      prev_pc <= pc_i;
      if (state == ST_HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (state == ST_RUN) stable_cnt <= pc_same ? stable_cnt + 1'b1 : '0;
      else                 stable_cnt <= '0;
      // Count freezes on the edge that leaves RUN.
      if ((state == ST_RUN) && (state_nxt == ST_RUN)) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign cycle_cnt_o = cycle_cnt;

  // ---------------- trace FIFO ----------------
  logic [TW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push_req, push_ok, pop, drop;
  logic [7:0]    drop_cnt;
  logic          overflow;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req = (state == ST_RUN) && wb_we_i && (wb_addr_i != 5'd0);
  assign pop      = !empty && trace_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {cycle_cnt, wb_addr_i, wb_data_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign trace_valid_o    = !empty;
  assign trace_data_o     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign trace_overflow_o = overflow;
  assign drop_cnt_o       = drop_cnt;

endmodule
